// File: rtl/mult_cmd_pkg.sv
// Shared command encodings for mult_unit / table_control initiators, plus the
// sequencer state type.
package mult_cmd_pkg;

    typedef enum logic [2:0] {
        MC_NOP    = 3'b000,
        MC_INIT   = 3'b100,
        MC_START  = 3'b010,
        MC_STEP   = 3'b011,
        MC_FINISH = 3'b101
    } mult_cmd_t;

    typedef enum logic [1:0] {
        TC_NOP  = 2'b00,
        TC_LOAD = 2'b01
    } table_cmd_t;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'b000,
        SEQ_ISSUE     = 3'b001,
        SEQ_WAIT_BUSY = 3'b010,
        SEQ_WAIT_DONE = 3'b011,
        SEQ_DONE      = 3'b100
    } seq_state_t;

endpackage

// File: rtl/mult_cmd_seq_idle_timeout.sv
// Loadable down-counter with expiry flag, used by idle-handshake initiators to
// bound how long they wait for a target to acknowledge a command.
module idle_timeout #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/mult_cmd_seq.sv
// Sequences INIT, START(+table LOAD), STEP x(e_words-1), FINISH into one
// mult_unit/table_control pair, waiting on both idle signals between commands.
module mult_cmd_seq
    import mult_cmd_pkg::*;
#(
    parameter int unsigned e_words      = 4,
    parameter int unsigned busy_timeout = 16
) (
    input  logic       clk,
    input  logic       ctrl_reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mult_idle,
    input  logic       table_idle,
    output logic [2:0] mult_cmd,
    output logic [1:0] table_cmd,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned IDX_W = $clog2(e_words + 2);
    localparam int unsigned TO_W  = $clog2(busy_timeout + 1);
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(e_words + 1);
    // The counter also runs during ISSUE, so the window spans busy_timeout cycles from issue.
    localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(busy_timeout - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             abort_q, abort_d;
    mult_cmd_t        mult_cmd_q, mult_cmd_d;
    table_cmd_t       table_cmd_q, table_cmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             to_load_s;
    logic             to_en_s;
    logic             to_expired_s;

    function automatic mult_cmd_t cmd_at(input logic [IDX_W-1:0] idx);
        if (idx == {IDX_W{1'b0}}) begin
            return MC_INIT;
        end else if (idx == START_IDX) begin
            return MC_START;
        end else if (idx == LAST_IDX) begin
            return MC_FINISH;
        end else begin
            return MC_STEP;
        end
    endfunction

    assign to_en_s = (state_q == SEQ_ISSUE) || (state_q == SEQ_WAIT_BUSY);

    idle_timeout #(
        .WIDTH (TO_W)
    ) u_idle_timeout (
        .clk        (clk),
        .rst_n      (ctrl_reset_n),
        .load_i     (to_load_s),
        .load_val_i (TO_LOAD),
        .en_i       (to_en_s),
        .expired_o  (to_expired_s)
    );

    // Sequencer next-state, index and sticky flag logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        abort_d   = abort_q | (abort & busy_q);
        error_d   = error_q;
        to_load_s = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start && mult_idle && table_idle) begin
                    state_d   = SEQ_ISSUE;
                    idx_d     = {IDX_W{1'b0}};
                    abort_d   = 1'b0;
                    error_d   = 1'b0;
                    to_load_s = 1'b1;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_ISSUE: begin
                state_d = SEQ_WAIT_BUSY;
            end
            SEQ_WAIT_BUSY: begin
                if (!mult_idle) begin
                    state_d = SEQ_WAIT_DONE;
                end else if (to_expired_s) begin
                    error_d = 1'b1;
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_WAIT_BUSY;
                end
            end
            SEQ_WAIT_DONE: begin
                if (mult_idle && table_idle) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SEQ_DONE;
                    end else if (abort_q || abort) begin
                        state_d = SEQ_IDLE;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        state_d   = SEQ_ISSUE;
                        to_load_s = 1'b1;
                    end
                end else begin
                    state_d = SEQ_WAIT_DONE;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so commands last exactly the ISSUE cycle.
    always_comb begin
        mult_cmd_d  = (state_d == SEQ_ISSUE) ? cmd_at(idx_d) : MC_NOP;
        table_cmd_d = ((state_d == SEQ_ISSUE) && (idx_d == START_IDX)) ? TC_LOAD : TC_NOP;
        busy_d      = (state_d != SEQ_IDLE);
        done_d      = (state_d == SEQ_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q     <= SEQ_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            abort_q     <= 1'b0;
            mult_cmd_q  <= MC_NOP;
            table_cmd_q <= TC_NOP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            abort_q     <= abort_d;
            mult_cmd_q  <= mult_cmd_d;
            table_cmd_q <= table_cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mult_cmd  = mult_cmd_q;
    assign table_cmd = table_cmd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mult_cmd_seq.sv
// Directed bench for mult_cmd_seq with a behavioural mult_unit responder.
module tb_mult_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mult_idle;
    logic       table_idle = 1'b1;
    logic [2:0] mult_cmd;
    logic [1:0] table_cmd;
    logic       busy, done, error;

    logic       start1 = 1'b0;
    logic       idle1;
    logic [2:0] mult_cmd1;
    logic [1:0] table_cmd1;
    logic       busy1, done1, error1;

    int checks = 0;
    int passes = 0;

    int  lat = 60;
    bit  respond = 1'b1;
    int  mcnt = 0;
    int  m1cnt = 0;

    logic [2:0] cmd_log[$];
    logic [2:0] cmd1_log[$];
    int  gaps[$];
    int  cyc = 0;
    int  last_cmd_cyc = -1;
    logic [2:0] prev_cmd = 3'b000;
    logic prev_done = 1'b0;
    int  wide_cnt = 0, load_cnt = 0, table_bad = 0, done_cnt = 0, done_busy_bad = 0, done1_cnt = 0;

    mult_cmd_seq #(.e_words(4), .busy_timeout(16)) dut (
        .clk(clk), .ctrl_reset_n(rst_n), .start(start), .abort(abort),
        .mult_idle(mult_idle), .table_idle(table_idle),
        .mult_cmd(mult_cmd), .table_cmd(table_cmd),
        .busy(busy), .done(done), .error(error)
    );

    mult_cmd_seq #(.e_words(1), .busy_timeout(16)) dut1 (
        .clk(clk), .ctrl_reset_n(rst_n), .start(start1), .abort(1'b0),
        .mult_idle(idle1), .table_idle(1'b1),
        .mult_cmd(mult_cmd1), .table_cmd(table_cmd1),
        .busy(busy1), .done(done1), .error(error1)
    );

    always #5 clk = ~clk;

    // mult_unit models: go busy for lat cycles after seeing any command.
    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt = 0;
            mult_idle = 1'b1;
            m1cnt = 0;
            idle1 = 1'b1;
        end else begin
            if (mult_cmd != 3'b000 && respond) begin
                mult_idle = 1'b0;
                mcnt = lat;
            end else if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) mult_idle = 1'b1;
            end
            if (mult_cmd1 != 3'b000) begin
                idle1 = 1'b0;
                m1cnt = 5;
            end else if (m1cnt > 0) begin
                m1cnt = m1cnt - 1;
                if (m1cnt == 0) idle1 = 1'b1;
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mult_cmd != 3'b000) begin
            cmd_log.push_back(mult_cmd);
            if (last_cmd_cyc >= 0) gaps.push_back(cyc - last_cmd_cyc);
            last_cmd_cyc = cyc;
        end
        if (prev_cmd != 3'b000 && mult_cmd != 3'b000) wide_cnt++;
        prev_cmd = mult_cmd;
        if (table_cmd == 2'b01) begin
            load_cnt++;
            if (mult_cmd != 3'b010) table_bad++;
        end else if (table_cmd != 2'b00) begin
            table_bad++;
        end
        if (done) done_cnt++;
        if (done && !busy) done_busy_bad++;
        if (prev_done && busy) done_busy_bad++;
        prev_done = done;
        if (mult_cmd1 != 3'b000) cmd1_log.push_back(mult_cmd1);
        if (done1) done1_cnt++;
    end

    task automatic clear_log();
        cmd_log.delete();
        cmd1_log.delete();
        gaps.delete();
        last_cmd_cyc = -1;
        wide_cnt = 0; load_cnt = 0; table_bad = 0; done_cnt = 0;
        done_busy_bad = 0; done1_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

    task automatic wait_cmd(input logic [2:0] c, input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (mult_cmd == c) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mult_cmd, table_cmd, busy, done, error} !== 8'h00)
            $display("FAIL reset_outputs got=%h want=00", {mult_cmd, table_cmd, busy, done, error});
        else passes++;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_pass();
        logic [2:0] exp_seq[6];
        exp_seq = '{3'd4, 3'd2, 3'd3, 3'd3, 3'd3, 3'd5};
        lat = 60; respond = 1'b1;
        clear_log();
        pulse_start();
        checks++;
        if (mult_cmd !== 3'b100 || busy !== 1'b1)
            $display("FAIL init_latency got cmd=%0d busy=%b want cmd=4 busy=1", mult_cmd, busy);
        else passes++;
        wait_idle(1000);
        checks++;
        if (busy !== 1'b0) $display("FAIL full_busy_end got=%b want=0", busy); else passes++;
        checks++;
        if (cmd_log.size() != 6) $display("FAIL full_cmd_count got=%0d want=6", cmd_log.size());
        else begin
            bit ok = 1'b1;
            for (int i = 0; i < 6; i++) if (cmd_log[i] !== exp_seq[i]) ok = 1'b0;
            if (!ok) $display("FAIL full_cmd_seq got=%0d,%0d,%0d,%0d,%0d,%0d want=4,2,3,3,3,5",
                              cmd_log[0], cmd_log[1], cmd_log[2], cmd_log[3], cmd_log[4], cmd_log[5]);
            else passes++;
        end
        checks++;
        if (wide_cnt != 0) $display("FAIL cmd_width got=%0d wide want=0", wide_cnt); else passes++;
        checks++;
        if (load_cnt != 1 || table_bad != 0)
            $display("FAIL table_load got loads=%0d bad=%0d want loads=1 bad=0", load_cnt, table_bad);
        else passes++;
        checks++;
        if (done_cnt != 1) $display("FAIL full_done got=%0d want=1", done_cnt); else passes++;
        checks++;
        if (done_busy_bad != 0) $display("FAIL done_busy_timing got=%0d want=0", done_busy_bad); else passes++;
        begin
            int bad = 0;
            foreach (gaps[i]) if (gaps[i] != lat + 1) bad++;
            checks++;
            if (gaps.size() != 5 || bad != 0)
                $display("FAIL cmd_spacing got n=%0d bad=%0d want n=5 bad=0 (gap %0d)", gaps.size(), bad, lat + 1);
            else passes++;
        end
        checks++;
        if (error !== 1'b0) $display("FAIL full_error got=%b want=0", error); else passes++;
    endtask

    task automatic test_e_words_one();
        clear_log();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy1) break;
        end
        checks++;
        if (cmd1_log.size() != 3 || cmd1_log[0] !== 3'd4 || cmd1_log[1] !== 3'd2 || cmd1_log[2] !== 3'd5)
            $display("FAIL ew1_seq got n=%0d want 4,2,5", cmd1_log.size());
        else passes++;
        checks++;
        if (done1_cnt != 1 || busy1 !== 1'b0)
            $display("FAIL ew1_done got done=%0d busy=%b want done=1 busy=0", done1_cnt, busy1);
        else passes++;
    endtask

    task automatic test_timeout();
        int n;
        respond = 1'b0;
        clear_log();
        pulse_start();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (error) break;
        end
        checks++;
        if (error !== 1'b1 || n != 16) $display("FAIL timeout_edge got err=%b after=%0d want err=1 after=16", error, n);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL timeout_busy got=%b want=0", busy); else passes++;
        repeat (10) @(negedge clk);
        checks++;
        if (cmd_log.size() != 1 || done_cnt != 0)
            $display("FAIL timeout_quiet got cmds=%0d done=%0d want cmds=1 done=0", cmd_log.size(), done_cnt);
        else passes++;
        respond = 1'b1; lat = 4;
        clear_log();
        pulse_start();
        checks++;
        if (error !== 1'b0 || mult_cmd !== 3'b100)
            $display("FAIL restart got err=%b cmd=%0d want err=0 cmd=4", error, mult_cmd);
        else passes++;
        wait_idle(200);
        checks++;
        if (cmd_log.size() != 6 || done_cnt != 1)
            $display("FAIL restart_pass got cmds=%0d done=%0d want cmds=6 done=1", cmd_log.size(), done_cnt);
        else passes++;
    endtask

    task automatic test_abort();
        bit seen;
        lat = 20; respond = 1'b1;
        clear_log();
        pulse_start();
        wait_cmd(3'b011, 200, seen);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_idle(300);
        checks++;
        if (!seen || cmd_log.size() != 3 || cmd_log[2] !== 3'b011)
            $display("FAIL abort_seq got seen=%b cmds=%0d want seen=1 cmds=3", seen, cmd_log.size());
        else passes++;
        checks++;
        if (done_cnt != 0 || busy !== 1'b0 || mult_idle !== 1'b1)
            $display("FAIL abort_end got done=%0d busy=%b idle=%b want 0,0,1", done_cnt, busy, mult_idle);
        else passes++;
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_log.size() != 3) $display("FAIL abort_quiet got=%0d want=3", cmd_log.size()); else passes++;
    endtask

    task automatic test_ignored_start();
        lat = 10; respond = 1'b1;
        clear_log();
        pulse_start();
        repeat (15) @(negedge clk);
        pulse_start();
        wait_idle(300);
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_log.size() != 6 || done_cnt != 1)
            $display("FAIL start_while_busy got cmds=%0d done=%0d want 6,1", cmd_log.size(), done_cnt);
        else passes++;
        table_idle = 1'b0;
        pulse_start();
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_log.size() != 6 || busy !== 1'b0)
            $display("FAIL start_table_busy got cmds=%0d busy=%b want 6,0", cmd_log.size(), busy);
        else passes++;
        table_idle = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int snap;
        lat = 30; respond = 1'b1;
        clear_log();
        pulse_start();
        wait_cmd(3'b010, 100, seen);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || {mult_cmd, table_cmd, busy, done, error} !== 8'h00)
            $display("FAIL reset_mid got seen=%b out=%h want seen=1 out=00", seen, {mult_cmd, table_cmd, busy, done, error});
        else passes++;
        snap = cmd_log.size();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (cmd_log.size() != snap || busy !== 1'b0)
            $display("FAIL reset_quiet got cmds=%0d busy=%b want cmds=%0d busy=0", cmd_log.size(), busy, snap);
        else passes++;
        lat = 3;
        pulse_start();
        checks++;
        if (mult_cmd !== 3'b100) $display("FAIL reset_restart got=%0d want=4", mult_cmd); else passes++;
        wait_idle(200);
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_e_words_one();
        test_timeout();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
